// File: rtl/ftoi_wb_buffer.sv
// In-order writeback buffer behind the ftoi converter: allocates a tag entry per issued
// conversion, captures untagged results in issue order, and drains {tag,data} to the regfile.
module ftoi_wb_buffer #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned TAG_W = 6
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     issue_valid,
   input  logic [TAG_W-1:0]         issue_tag,
   output logic                     issue_ready,
   output logic                     cvt_start,
   input  logic                     cvt_result_valid,
   input  logic [31:0]              cvt_result,
   output logic                     wb_valid,
   output logic [TAG_W-1:0]         wb_tag,
   output logic [31:0]              wb_data,
   input  logic                     wb_ready,
   output logic [$clog2(DEPTH):0]   inflight_count,
   output logic                     err_orphan
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];
   localparam logic [AW:0] PTR_ONE    = 1;

   logic [AW:0]       head_ptr;
   logic [AW:0]       fill_ptr;
   logic [AW:0]       tail_ptr;
   logic [AW:0]       count_q;
   logic              orphan_q;
   logic [TAG_W-1:0]  tag_mem  [DEPTH];
   logic [31:0]       data_mem [DEPTH];
   logic [DEPTH-1:0]  filled_q;

   logic [AW-1:0]     head_idx;
   logic [AW-1:0]     fill_idx;
   logic [AW-1:0]     tail_idx;
   logic              accept;
   logic              pending;
   logic              capture;
   logic              pop;

   assign head_idx = head_ptr[AW-1:0];
   assign fill_idx = fill_ptr[AW-1:0];
   assign tail_idx = tail_ptr[AW-1:0];

   // Ready depends only on the registered count, so a pop never opens a slot in the same cycle.
   assign issue_ready = (count_q != FULL_COUNT);
   assign accept      = issue_valid & issue_ready;
   assign cvt_start   = accept;

   assign pending = (fill_ptr != tail_ptr);
   assign capture = cvt_result_valid & pending;

   assign wb_valid = filled_q[head_idx];
   assign wb_tag   = tag_mem[head_idx];
   assign wb_data  = data_mem[head_idx];
   assign pop      = wb_valid & wb_ready;

   assign inflight_count = count_q;
   assign err_orphan     = orphan_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_ptr <= '0;
         fill_ptr <= '0;
         tail_ptr <= '0;
         count_q  <= '0;
         orphan_q <= 1'b0;
      end else begin
         if (accept)  tail_ptr <= tail_ptr + PTR_ONE;
         if (capture) fill_ptr <= fill_ptr + PTR_ONE;
         if (pop)     head_ptr <= head_ptr + PTR_ONE;
         if (cvt_result_valid && !pending) orphan_q <= 1'b1;
         case ({accept, pop})
            2'b10:   count_q <= count_q + PTR_ONE;
            2'b01:   count_q <= count_q - PTR_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   // Allocation, capture and pop always address distinct entries in a given cycle,
   // so the per-entry updates below never collide.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filled_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            tag_mem[i]  <= '0;
            data_mem[i] <= '0;
         end
      end else begin
         if (accept) begin
            tag_mem[tail_idx]  <= issue_tag;
            filled_q[tail_idx] <= 1'b0;
         end
         if (capture) begin
            data_mem[fill_idx] <= cvt_result;
            filled_q[fill_idx] <= 1'b1;
         end
         if (pop) filled_q[head_idx] <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ftoi_wb_buffer.sv
// Directed bench for ftoi_wb_buffer: expected {tag,data} pairs are queued as results are
// driven, and a negedge monitor pops and compares every writeback handshake.
module tb_ftoi_wb_buffer;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned TAG_W = 6;

   logic              clk = 1'b0;
   logic              rst;
   logic              issue_valid;
   logic [TAG_W-1:0]  issue_tag;
   logic              issue_ready;
   logic              cvt_start;
   logic              cvt_result_valid;
   logic [31:0]       cvt_result;
   logic              wb_valid;
   logic [TAG_W-1:0]  wb_tag;
   logic [31:0]       wb_data;
   logic              wb_ready;
   logic [3:0]        inflight_count;
   logic              err_orphan;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [31:0]      data;
   } wb_t;

   wb_t exp_q[$];
   int  n_cmp = 0;
   int  n_err = 0;

   ftoi_wb_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk              (clk),
      .rst              (rst),
      .issue_valid      (issue_valid),
      .issue_tag        (issue_tag),
      .issue_ready      (issue_ready),
      .cvt_start        (cvt_start),
      .cvt_result_valid (cvt_result_valid),
      .cvt_result       (cvt_result),
      .wb_valid         (wb_valid),
      .wb_tag           (wb_tag),
      .wb_data          (wb_data),
      .wb_ready         (wb_ready),
      .inflight_count   (inflight_count),
      .err_orphan       (err_orphan)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_result(input logic [31:0] d, input logic [TAG_W-1:0] t);
      wb_t e;
      cvt_result_valid = 1'b1;
      cvt_result       = d;
      e.tag  = t;
      e.data = d;
      exp_q.push_back(e);
   endtask

   // Monitor: every accepted writeback must match the oldest expected pair.
   always @(negedge clk) begin
      wb_t got;
      wb_t exp;
      if (!rst && wb_valid && wb_ready) begin
         got.tag  = wb_tag;
         got.data = wb_data;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL wb_unexpected: got tag %0d data 0x%h expected no writeback", wb_tag, wb_data);
         end else begin
            exp = exp_q.pop_front();
            check("wb_pop", 64'(got), 64'(exp));
         end
      end
   end

   initial begin
      rst = 1'b1;
      issue_valid = 1'b0;
      issue_tag = '0;
      cvt_result_valid = 1'b0;
      cvt_result = '0;
      wb_ready = 1'b0;
      #1;
      check("rst_issue_ready", 64'(issue_ready), 64'(1));
      check("rst_cvt_start",   64'(cvt_start), 64'(0));
      check("rst_wb_valid",    64'(wb_valid), 64'(0));
      check("rst_wb_tag",      64'(wb_tag), 64'(0));
      check("rst_wb_data",     64'(wb_data), 64'(0));
      check("rst_inflight",    64'(inflight_count), 64'(0));
      check("rst_orphan",      64'(err_orphan), 64'(0));
      #11 rst = 1'b0;
      step();

      // 1: single conversion
      issue_valid = 1'b1; issue_tag = 6'd5; wb_ready = 1'b1;
      #1 check("t1_cvt_start", 64'(cvt_start), 64'(1));
      step();
      issue_valid = 1'b0;
      drive_result(32'h0000_002A, 6'd5);
      check("t1_inflight_1", 64'(inflight_count), 64'(1));
      check("t1_wb_valid_0", 64'(wb_valid), 64'(0));
      step();
      cvt_result_valid = 1'b0;
      check("t1_wb_valid_1", 64'(wb_valid), 64'(1));
      step();
      check("t1_inflight_0", 64'(inflight_count), 64'(0));
      check("t1_wb_valid_end", 64'(wb_valid), 64'(0));

      // 2: fill to DEPTH under backpressure, then drain
      wb_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         issue_valid = 1'b1; issue_tag = 6'(i);
         check("t2_issue_ready_open", 64'(issue_ready), 64'(1));
         step();
      end
      check("t2_issue_ready_full", 64'(issue_ready), 64'(0));
      check("t2_inflight_8", 64'(inflight_count), 64'(8));
      issue_tag = 6'd63;
      #1 check("t2_cvt_start_full", 64'(cvt_start), 64'(0));
      issue_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive_result(32'h100 + 32'(i), 6'(i));
         step();
      end
      cvt_result_valid = 1'b0;
      check("t2_head_valid", 64'(wb_valid), 64'(1));
      wb_ready = 1'b1;
      #1 check("t2_ready_no_comb", 64'(issue_ready), 64'(0));
      step();
      check("t2_ready_after_pop", 64'(issue_ready), 64'(1));
      check("t2_inflight_7", 64'(inflight_count), 64'(7));
      repeat (7) step();
      check("t2_inflight_0", 64'(inflight_count), 64'(0));
      check("t2_drained", 64'(exp_q.size()), 64'(0));

      // 3: steady state at count 3
      wb_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         issue_valid = 1'b1; issue_tag = 6'(20 + i);
         step();
      end
      issue_valid = 1'b0;
      drive_result(32'hA000_0014, 6'd20);
      step();
      drive_result(32'hA000_0015, 6'd21);
      step();
      cvt_result_valid = 1'b0;
      for (int k = 0; k < 6; k++) begin
         wb_ready = 1'b1;
         issue_valid = 1'b1; issue_tag = 6'(23 + k);
         drive_result(32'hA000_0016 + 32'(k), 6'(22 + k));
         check("t3_inflight_3", 64'(inflight_count), 64'(3));
         check("t3_wb_valid", 64'(wb_valid), 64'(1));
         step();
      end
      issue_valid = 1'b0;
      drive_result(32'hA000_001C, 6'd28);
      step();
      cvt_result_valid = 1'b0;
      repeat (2) step();
      check("t3_inflight_0", 64'(inflight_count), 64'(0));

      // 4: orphan result
      cvt_result_valid = 1'b1; cvt_result = 32'h1234_5678;
      step();
      cvt_result_valid = 1'b0;
      check("t4_orphan", 64'(err_orphan), 64'(1));
      check("t4_wb_valid", 64'(wb_valid), 64'(0));
      check("t4_inflight", 64'(inflight_count), 64'(0));

      // 5: extreme values
      wb_ready = 1'b1;
      issue_valid = 1'b1; issue_tag = 6'd33;
      step();
      issue_tag = 6'd34; drive_result(32'hFFFF_FFFF, 6'd33);
      step();
      issue_tag = 6'd35; drive_result(32'h8000_0000, 6'd34);
      step();
      issue_valid = 1'b0; drive_result(32'h7FFF_FFFF, 6'd35);
      step();
      cvt_result_valid = 1'b0;
      repeat (2) step();
      check("t5_inflight_0", 64'(inflight_count), 64'(0));
      check("t5_orphan_sticky", 64'(err_orphan), 64'(1));
      check("t5_drained", 64'(exp_q.size()), 64'(0));

      // 6: async reset mid-cycle with 4 entries, 2 filled
      wb_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         issue_valid = 1'b1; issue_tag = 6'(40 + i);
         step();
      end
      issue_valid = 1'b0;
      cvt_result_valid = 1'b1; cvt_result = 32'hC0DE_0028;
      step();
      cvt_result = 32'hC0DE_0029;
      step();
      cvt_result_valid = 1'b0;
      check("t6_pre_wb_tag", 64'(wb_tag), 64'(40));
      check("t6_pre_inflight", 64'(inflight_count), 64'(4));
      #3 rst = 1'b1;
      #1;
      check("t6_wb_valid", 64'(wb_valid), 64'(0));
      check("t6_issue_ready", 64'(issue_ready), 64'(1));
      check("t6_inflight", 64'(inflight_count), 64'(0));
      check("t6_wb_data", 64'(wb_data), 64'(0));
      check("t6_orphan_clr", 64'(err_orphan), 64'(0));
      #3 rst = 1'b0;
      step();
      cvt_result_valid = 1'b1; cvt_result = 32'h0000_DEAD;
      step();
      cvt_result_valid = 1'b0;
      check("t6_orphan_set", 64'(err_orphan), 64'(1));
      check("t6_wb_valid_end", 64'(wb_valid), 64'(0));

      // same-cycle issue does not give a result a home
      #3 rst = 1'b1;
      #3 rst = 1'b0;
      step();
      issue_valid = 1'b1; issue_tag = 6'd50;
      cvt_result_valid = 1'b1; cvt_result = 32'h0000_0055;
      step();
      issue_valid = 1'b0; cvt_result_valid = 1'b0;
      check("t7_orphan", 64'(err_orphan), 64'(1));
      check("t7_inflight", 64'(inflight_count), 64'(1));
      check("t7_wb_valid", 64'(wb_valid), 64'(0));
      wb_ready = 1'b1;
      drive_result(32'h0000_0066, 6'd50);
      step();
      cvt_result_valid = 1'b0;
      step();
      check("t7_inflight_0", 64'(inflight_count), 64'(0));
      check("final_drained", 64'(exp_q.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
